// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU operand sequencer: state encodings, flag bit positions, stage width.
// Latency: n/a (package). Backpressure: n/a.
package alu_seq_pkg;

    localparam int STAGE_W = 3;

    typedef enum logic [STAGE_W-1:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_SHOW = 3'd4
    } state_t;

    localparam int FLAG_Z = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a level input such as a debounced button.
// Latency: pulse is combinational from sig and the registered previous level.
// Backpressure: none; one pulse per low-to-high transition.
module rise_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic sig,
    output logic pulse
);

    logic sig_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_q <= 1'b0;
        end else begin
            sig_q <= sig;
        end
    end

    assign pulse = sig & ~sig_q;

endmodule

// File: rtl/alu_op_sequencer.sv
// Steps A, B and ALUControl in from a shared switch bus, then captures ALU result/flags.
// Latency: result/flags/done update one cycle after OP capture. Optional: ALU_SEQ_ACCUM_EN.
// Backpressure: none; presses during S_EXEC are ignored, clear overrides a press.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       data_in,
    input  logic [3:0]         op_in,
    input  logic               load,
    input  logic               clear,
    output logic [N-1:0]       alu_a,
    output logic [N-1:0]       alu_b,
    output logic [3:0]         alu_ctrl,
    input  logic [N-1:0]       alu_result,
    input  logic [3:0]         alu_flags,
    output logic [N-1:0]       result,
    output logic [3:0]         flags,
    output logic [STAGE_W-1:0] stage,
    output logic               busy,
    output logic               done
);

    state_t       state;
    logic [N-1:0] a_q;
    logic [N-1:0] b_q;
    logic [3:0]   op_q;
    logic [N-1:0] result_q;
    logic [3:0]   flags_q;
    logic         done_q;
    logic         ld_pulse;

    rise_detect u_rise_detect (
        .clk   (clk),
        .rst_n (rst_n),
        .sig   (load),
        .pulse (ld_pulse)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            result_q <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (clear) begin
                state    <= S_A;
                a_q      <= '0;
                b_q      <= '0;
                op_q     <= '0;
                result_q <= '0;
                flags_q  <= '0;
            end else begin
                case (state)
                    S_A: begin
                        if (ld_pulse) begin
                            a_q   <= data_in;
                            state <= S_B;
                        end
                    end
                    S_B: begin
                        if (ld_pulse) begin
                            b_q   <= data_in;
                            state <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (ld_pulse) begin
                            op_q  <= op_in;
                            state <= S_EXEC;
                        end
                    end
                    S_EXEC: begin
                        // Operands have been stable for this whole cycle, so the ALU output is settled.
                        result_q <= alu_result;
                        flags_q  <= alu_flags;
                        done_q   <= 1'b1;
                        state    <= S_SHOW;
                    end
                    S_SHOW: begin
                        if (ld_pulse) begin
`ifdef ALU_SEQ_ACCUM_EN
                            a_q   <= result_q;
                            b_q   <= data_in;
                            state <= S_OP;
`else
                            a_q   <= data_in;
                            state <= S_B;
`endif
                        end
                    end
                    default: state <= S_A;
                endcase
            end
        end
    end

    assign alu_a    = a_q;
    assign alu_b    = b_q;
    assign alu_ctrl = op_q;
    assign result   = result_q;
    assign flags    = flags_q;
    assign stage    = state;
    assign busy     = (state == S_EXEC);
    assign done     = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench for alu_op_sequencer with a behavioural stand-in for the ALU.
module tb_alu_op_sequencer;

    localparam int N = 3;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] data_in;
    logic [3:0]   op_in;
    logic         load;
    logic         clear;
    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [3:0]   alu_ctrl;
    logic [N-1:0] alu_result;
    logic [3:0]   alu_flags;
    logic [N-1:0] result;
    logic [3:0]   flags;
    logic [2:0]   stage;
    logic         busy;
    logic         done;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;

    alu_op_sequencer #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .op_in      (op_in),
        .load       (load),
        .clear      (clear),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_ctrl   (alu_ctrl),
        .alu_result (alu_result),
        .alu_flags  (alu_flags),
        .result     (result),
        .flags      (flags),
        .stage      (stage),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Stand-in ALU: sum truncated to N bits, flags derived from the control code.
    always_comb begin
        alu_result = alu_a + alu_b;
        alu_flags  = {alu_ctrl[2:0], 1'b0};
    end

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic press(input logic [N-1:0] d, input logic [3:0] op);
        @(negedge clk);
        data_in = d;
        op_in   = op;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; data_in = '0; op_in = '0; load = 1'b0; clear = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (stage !== 3'd0) begin errors++; $display("FAIL reset_stage: got %0d want 0", stage); end
        checks++; if ({alu_a, alu_b, alu_ctrl} !== 10'd0) begin errors++; $display("FAIL reset_regs: got %h want 0", {alu_a, alu_b, alu_ctrl}); end
        checks++; if ({result, flags, busy, done} !== 9'd0) begin errors++; $display("FAIL reset_outs: got %h want 0", {result, flags, busy, done}); end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_op();
        int d0;
        press(3'b101, 4'h0);
        press(3'b010, 4'h0);
        d0 = done_cnt;
        press(3'b000, 4'h1);
        // Now in S_EXEC.
        checks++; if (busy !== 1'b1 || stage !== 3'd3) begin errors++; $display("FAIL exec_busy: got busy=%b stage=%0d want 1/3", busy, stage); end
        checks++; if ({alu_a, alu_b, alu_ctrl} !== {3'd5, 3'd2, 4'h1}) begin errors++; $display("FAIL exec_operands: got a=%0d b=%0d c=%0d want 5 2 1", alu_a, alu_b, alu_ctrl); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL exec_done_early: got %b want 0", done); end
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_pulse: got %b want 1", done); end
        checks++; if (result !== 3'd7 || flags !== 4'b0010) begin errors++; $display("FAIL basic_result: got r=%0d f=%b want 7 0010", result, flags); end
        checks++; if (stage !== 3'd4 || busy !== 1'b0) begin errors++; $display("FAIL basic_stage: got %0d busy=%b want 4 0", stage, busy); end
        repeat (4) @(negedge clk);
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL done_once: got %0d pulses want 1", done_cnt - d0); end
    endtask

    task automatic test_show_load();
        do_clear();
        press(3'd4, 4'h0);
        press(3'd2, 4'h0);
        press(3'd0, 4'h3);
        @(negedge clk);
        checks++; if (result !== 3'd6 || flags !== 4'b0110) begin errors++; $display("FAIL show_prior: got r=%0d f=%b want 6 0110", result, flags); end
        press(3'd3, 4'h0);
`ifdef ALU_SEQ_ACCUM_EN
        checks++; if (alu_a !== 3'd6 || alu_b !== 3'd3 || stage !== 3'd2) begin errors++; $display("FAIL show_accum: got a=%0d b=%0d stage=%0d want 6 3 2", alu_a, alu_b, stage); end
`else
        checks++; if (alu_a !== 3'd3 || stage !== 3'd1) begin errors++; $display("FAIL show_restart: got a=%0d stage=%0d want 3 1", alu_a, stage); end
`endif
        checks++; if (result !== 3'd6) begin errors++; $display("FAIL show_hold_result: got %0d want 6", result); end
    endtask

    task automatic test_clear_priority();
        @(negedge clk);
        data_in = 3'd5;
        clear   = 1'b1;
        load    = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        @(negedge clk);
        checks++; if (stage !== 3'd0) begin errors++; $display("FAIL clear_stage: got %0d want 0", stage); end
        checks++; if ({alu_a, alu_b, alu_ctrl, result, flags} !== 17'd0) begin errors++; $display("FAIL clear_regs: got %h want 0", {alu_a, alu_b, alu_ctrl, result, flags}); end
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_hold_load();
        @(negedge clk);
        data_in = 3'd6;
        load    = 1'b1;
        repeat (10) @(negedge clk);
        load    = 1'b0;
        checks++; if (stage !== 3'd1 || alu_a !== 3'd6 || alu_b !== 3'd0) begin errors++; $display("FAIL hold_one_step: got stage=%0d a=%0d b=%0d want 1 6 0", stage, alu_a, alu_b); end
    endtask

    task automatic test_exec_ignore();
        press(3'd1, 4'h0);
        press(3'd0, 4'hA);
        checks++; if (stage !== 3'd3) begin errors++; $display("FAIL ign_enter_exec: got %0d want 3", stage); end
        #2 data_in = 3'd2; op_in = 4'h5; load = 1'b1;
        @(negedge clk);
        checks++; if (stage !== 3'd4) begin errors++; $display("FAIL ign_stage: got %0d want 4", stage); end
        checks++; if ({alu_a, alu_b, alu_ctrl} !== {3'd6, 3'd1, 4'hA}) begin errors++; $display("FAIL ign_operands: got a=%0d b=%0d c=%h want 6 1 a", alu_a, alu_b, alu_ctrl); end
        checks++; if (result !== 3'd7 || flags !== 4'b0100) begin errors++; $display("FAIL ign_result: got r=%0d f=%b want 7 0100", result, flags); end
        load = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        int d0;
        do_clear();
        press(3'd1, 4'h0);
        press(3'd1, 4'h0);
        d0 = done_cnt;
        press(3'd0, 4'h7);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (stage !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL rst_mid_stage: got %0d busy=%b want 0 0", stage, busy); end
        checks++; if ({alu_a, alu_b, alu_ctrl, result, flags} !== 17'd0) begin errors++; $display("FAIL rst_mid_regs: got %h want 0", {alu_a, alu_b, alu_ctrl, result, flags}); end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (done_cnt !== d0 || result !== 3'd0) begin errors++; $display("FAIL rst_no_done: got pulses=%0d r=%0d want 0 0", done_cnt - d0, result); end
    endtask

    initial begin
        test_reset();
        test_basic_op();
        test_show_load();
        test_clear_priority();
        test_hold_load();
        test_exec_ignore();
        test_reset_mid_exec();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

- Sequential front/back stage for the N-bit ALU.
- Collects operand A, operand B and a 4-bit ALUControl code from one shared switch bus, one button press per step.
- Presents the latched values to the ALU, then captures the ALU result and Z/N/V/C flags into held output registers for display.
- The ALU is instantiated beside this block at top level; this block only drives its inputs and samples its outputs.

## Interface
- N, 3, operand/result width; must match the ALU's n
- clk  in  1  system clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- data_in  in  N  operand switches
- op_in  in  4  ALUControl switches
- load  in  1  step button, level; internally rising-edge detected
- clear  in  1  synchronous clear, level, priority over load
- alu_a  out  N  to ALU a; always driven from A register
- alu_b  out  N  to ALU b; always driven from B register
- alu_ctrl  out  4  to ALU ALUControl; always driven from OP register
- alu_result  in  N  from ALU result
- alu_flags  in  4  from ALU {Z,N,V,C}
- result  out  N  held result register
- flags  out  4  held {Z,N,V,C} register
- stage  out  3  current state encoding, for LEDs
- busy  out  1  high while in S_EXEC
- done  out  1  one-cycle pulse when result/flags update

## Operation
- load_q is the registered load level.
- ld_pulse = load & ~load_q.
  - A held button yields exactly one step.
  - load high in the first cycle after reset counts as a press, because load_q resets to 0.
- States and encodings:
  - S_A = 0: ld_pulse → A ← data_in, go to S_B.
  - S_B = 1: ld_pulse → B ← data_in, go to S_OP.
  - S_OP = 2: ld_pulse → OP ← op_in, go to S_EXEC.
  - S_EXEC = 3: one cycle only, ld_pulse ignored. At the exit edge, result ← alu_result, flags ← alu_flags, done ← 1. Go to S_SHOW.
  - S_SHOW = 4: result/flags held. ld_pulse → A ← data_in, go to S_B. Prior result stays visible until the next S_EXEC.
- clear, from any state:
  - Go to S_A.
  - Zero A, B, OP, result and flags; done ← 0.
  - clear with ld_pulse in the same cycle: clear wins and the press is lost.
  - load_q still tracks load during clear.
- No opcode legality check; all 16 codes pass through unchanged.
- Arithmetic is entirely in the ALU; this block performs no width extension.

## Timing
- Reset: state S_A; A, B, OP, result, flags, load_q = 0; done = 0; busy = 0; stage = 0.
- Latency: OP captured at edge k → S_EXEC during cycle k..k+1 → result/flags valid and done = 1 after edge k+1, for exactly one cycle.
- alu_a/alu_b/alu_ctrl are stable for the whole S_EXEC cycle. The ALU path must settle within one clk period.
- rst_n asserted mid-operation: everything returns to reset values immediately; no partial result is captured.

## Configuration
- ALU_SEQ_ACCUM_EN defined, in S_SHOW: ld_pulse → A ← result, B ← data_in, go to S_OP. This chains operations on the previous result.
- Not defined: S_SHOW behaves as described under Operation.
- All other behaviour is identical in both builds.

## Structure
- Package alu_seq_pkg:
  - state enum with the fixed encodings above.
  - Flag bit indices: Z = 3, N = 2, V = 1, C = 0.
  - Width of stage.
- Sub-module rise_detect: load_q register plus pulse output. Async active-low reset to 0.

## Test plan
The bench drives alu_result/alu_flags directly with a behavioural model, so tests are independent of ALU encoding.
- Reset, then press load three times with data_in = 3'b101, 3'b010 and op_in = 4'h1; model returns result 3'b111, flags 4'b0010 → alu_a = 5, alu_b = 2, alu_ctrl = 1. done high exactly once, one cycle after the S_EXEC edge; result = 7, flags = 0010, stage = 4.
- Hold load high for 10 cycles in S_A → only A captured, stage = 1.
- In S_B, assert clear and a load rising edge in the same cycle → stage = 0; A, B, result and flags all 0; no capture.
- Assert rst_n low mid-way through S_EXEC → outputs at reset values immediately; done never pulses.
- Without the macro, press load in S_SHOW with data_in = 3 → A = 3, stage = 1, result unchanged. With ALU_SEQ_ACCUM_EN and prior result 6 → A = 6, B = 3, stage = 2.
- Attempt a load rising edge during S_EXEC → ignored; state advances to S_SHOW.
